// File: rtl/boot_copy_sequencer.sv
// Copies the boot-ROM image into SDRAM over the download port, reads it back to verify,
// re-copies a bounded number of times on mismatch, then requests a CPU launch.
module boot_copy_sequencer #(
    parameter logic [15:0] ROM_END   = 16'd275,
    parameter logic [15:0] EXEC_ADDR = 16'h0000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sdram_clk_ref,
    input  logic        sdram_ready,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        dn_go,
    output logic        dn_wr,
    output logic        dn_rd,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    input  logic [7:0]  dn_rdata,
    output logic        execute_enable,
    output logic [15:0] execute_addr,
    output logic        done,
    output logic        error,
    output logic [1:0]  retry_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StVSetup,
        StVStrobe,
        StExec,
        StDone,
        StFail
    } state_e;

    localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  retry_q, retry_d;
    logic        go_q, go_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        exec_q, exec_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        mism_q, mism_d;
    logic        ref_last_q;

    logic tick;
    logic last_addr;
    logic mism_now;

    // A tick is the first qualifying cycle of each SDRAM reference pulse.
    assign tick      = sdram_ready & sdram_clk_ref & ~ref_last_q;
    assign last_addr = (addr_q == ROM_END);
    assign mism_now  = mism_q | (dn_rdata != rom_data);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        retry_d = retry_q;
        go_d    = go_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        exec_d  = exec_q;
        done_d  = done_q;
        error_d = error_q;
        mism_d  = mism_q;

        if (start) begin
            state_d = StWSetup;
            addr_d  = 16'd0;
            retry_d = 2'd0;
            mism_d  = 1'b0;
            go_d    = 1'b1;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            exec_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else if (tick) begin
            case (state_q)
                StWSetup: begin
                    data_d  = rom_data;
                    wr_d    = 1'b1;
                    state_d = StWStrobe;
                end
                StWStrobe: begin
                    wr_d = 1'b0;
                    if (last_addr) begin
                        addr_d  = 16'd0;
                        state_d = StVSetup;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        state_d = StWSetup;
                    end
                end
                StVSetup: begin
                    rd_d    = 1'b1;
                    state_d = StVStrobe;
                end
                StVStrobe: begin
                    rd_d   = 1'b0;
                    mism_d = mism_now;
                    if (!last_addr) begin
                        addr_d  = addr_q + 16'd1;
                        state_d = StVSetup;
                    end else if (!mism_now) begin
                        exec_d  = 1'b1;
                        state_d = StExec;
                    end else if (retry_q < MaxRetry) begin
                        retry_d = retry_q + 2'd1;
                        mism_d  = 1'b0;
                        addr_d  = 16'd0;
                        state_d = StWSetup;
                    end else begin
                        state_d = StFail;
                    end
                end
                StExec: begin
                    exec_d  = 1'b0;
                    go_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
                // Download stays asserted so the CPU remains held after a failed verify.
                StFail: begin
                    error_d = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= 16'd0;
            data_q     <= 8'd0;
            retry_q    <= 2'd0;
            go_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            exec_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mism_q     <= 1'b0;
            ref_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            go_q       <= go_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            exec_q     <= exec_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mism_q     <= mism_d;
            ref_last_q <= sdram_clk_ref;
        end
    end

    assign rom_addr       = addr_q;
    assign dn_addr        = addr_q;
    assign dn_data        = data_q;
    assign dn_go          = go_q;
    assign dn_wr          = wr_q;
    assign dn_rd          = rd_q;
    assign execute_enable = exec_q;
    assign execute_addr   = EXEC_ADDR;
    assign done           = done_q;
    assign error          = error_q;
    assign retry_count    = retry_q;

endmodule

// File: tb/tb_boot_copy_sequencer.sv
// Scoreboard bench for boot_copy_sequencer: random ROM images and corruption patterns,
// expected strobe sequences and outcomes produced by a pass-level reference model.
module tb_boot_copy_sequencer;

    localparam int          N        = 4;
    localparam logic [15:0] RomEnd   = 16'd3;
    localparam logic [15:0] ExecAddr = 16'hA5C0;
    localparam int          MaxRetry = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sdram_clk_ref;
    logic        sdram_ready;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        dn_go;
    logic        dn_wr;
    logic        dn_rd;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  dn_rdata;
    logic        execute_enable;
    logic [15:0] execute_addr;
    logic        done;
    logic        error;
    logic [1:0]  retry_count;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        bit is_fail;
        int ticks;
        int retry;
    } out_t;

    wr_t  exp_wr[$];
    int   exp_rd[$];
    out_t exp_out[$];

    logic [7:0] rom[N];
    logic [7:0] mem[N];
    int pass_idx       = 0;
    int corrupt_base   = 0;
    int corrupt_passes = 0;
    int corrupt_addr   = -1;
    int n_tests        = 0;
    int n_fail         = 0;
    int tb_ticks       = 0;
    int exec_cnt       = 0;
    logic tb_ref_prev  = 1'b0;
    logic corrupt_now;

    boot_copy_sequencer #(
        .ROM_END  (RomEnd),
        .EXEC_ADDR(ExecAddr),
        .MAX_RETRY(MaxRetry)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .start         (start),
        .sdram_clk_ref (sdram_clk_ref),
        .sdram_ready   (sdram_ready),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .dn_go         (dn_go),
        .dn_wr         (dn_wr),
        .dn_rd         (dn_rd),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_rdata      (dn_rdata),
        .execute_enable(execute_enable),
        .execute_addr  (execute_addr),
        .done          (done),
        .error         (error),
        .retry_count   (retry_count)
    );

    always #5 clk_sys = ~clk_sys;

    assign rom_data    = (rom_addr < 16'(N)) ? rom[rom_addr[1:0]] : 8'h00;
    assign corrupt_now = (int'(dn_addr) == corrupt_addr) &&
                         (pass_idx - corrupt_base <= corrupt_passes);
    assign dn_rdata    = corrupt_now ? (mem[dn_addr[1:0]] ^ 8'h5A) : mem[dn_addr[1:0]];

    // Reference pulse: one cycle high out of every 16, random phase.
    initial begin
        logic [3:0] ph;
        ph = 4'($urandom_range(0, 15));
        sdram_clk_ref = 1'b0;
        forever begin
            @(negedge clk_sys);
            ph = ph + 4'd1;
            sdram_clk_ref = (ph == 4'd0);
        end
    end

    always @(posedge clk_sys) begin
        tb_ref_prev <= sdram_clk_ref;
        if (start) tb_ticks <= 0;
        else if (sdram_ready && sdram_clk_ref && !tb_ref_prev) tb_ticks <= tb_ticks + 1;
    end

    // Ideal SDRAM; a write pass is counted each time a write strobe starts at address 0.
    initial begin
        logic wr_p;
        wr_p = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (dn_wr && !wr_p && dn_addr == 16'd0) pass_idx++;
            if (dn_wr) mem[dn_addr[1:0]] = dn_data;
            wr_p = dn_wr;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Pass-level model: every pass writes then reads all N bytes; pass p mismatches when p < k.
    task automatic expect_run(input int k);
        for (int p = 0; p <= MaxRetry; p++) begin
            for (int a = 0; a < N; a++) exp_wr.push_back('{addr: a, data: int'(rom[a])});
            for (int a = 0; a < N; a++) exp_rd.push_back(a);
            if (p >= k) begin
                exp_out.push_back('{is_fail: 1'b0, ticks: 4 * N * (p + 1) + 1, retry: p});
                break;
            end
            if (p == MaxRetry) exp_out.push_back('{is_fail: 1'b1, ticks: 0, retry: p});
        end
    endtask

    // Monitor: pops the scoreboard on every strobe start and on each outcome edge.
    initial begin
        logic wr_p, rd_p, ex_p, done_p, err_p;
        int   cyc, ex_start;
        wr_t  ew;
        int   er;
        out_t eo;
        wr_p = 1'b0; rd_p = 1'b0; ex_p = 1'b0; done_p = 1'b0; err_p = 1'b0;
        cyc = 0; ex_start = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (!reset_n) begin
                exec_cnt = 0;
            end else begin
                if (start) exec_cnt = 0;
                if (dn_wr && dn_rd) fail_now("strobe_overlap", "got dn_wr=dn_rd=1, required exclusive");
                if (dn_wr && !wr_p) begin
                    if (exp_wr.size() == 0) begin
                        fail_now("write_unexpected", "got a dn_wr pulse, required none");
                    end else begin
                        ew = exp_wr.pop_front();
                        check("write_addr", dn_addr, ew.addr);
                        check("write_data", dn_data, ew.data);
                    end
                end
                if (dn_rd && !rd_p) begin
                    if (exp_rd.size() == 0) begin
                        fail_now("read_unexpected", "got a dn_rd pulse, required none");
                    end else begin
                        er = exp_rd.pop_front();
                        check("read_addr", dn_addr, er);
                    end
                end
                if (!execute_enable && ex_p) begin
                    check("exec_width", cyc - ex_start, 16);
                    exec_cnt++;
                end
                if (execute_enable && !ex_p) begin
                    ex_start = cyc;
                    check("exec_addr", execute_addr, ExecAddr);
                end
                if ((done && !done_p) || (error && !err_p)) begin
                    if (exp_out.size() == 0) begin
                        fail_now("outcome_unexpected", "got done/error edge, required none");
                    end else begin
                        eo = exp_out.pop_front();
                        check("outcome_is_fail", error, eo.is_fail);
                        check("outcome_retry", retry_count, eo.retry);
                        check("outcome_dn_go", dn_go, eo.is_fail);
                        check("outcome_exec_pulses", exec_cnt, eo.is_fail ? 0 : 1);
                        if (!eo.is_fail) check("outcome_ticks", tb_ticks, eo.ticks);
                    end
                end
            end
            wr_p = dn_wr; rd_p = dn_rd; ex_p = execute_enable; done_p = done; err_p = error;
        end
    end

    // mode 0: write at a, 1: read at a, 2: idle-strobe at a, 3: execute_enable, 4: done|error
    task automatic wait_for(input int mode, input logic [15:0] a, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge clk_sys);
            case (mode)
                0: hit = dn_wr && dn_addr == a;
                1: hit = dn_rd && dn_addr == a;
                2: hit = !dn_rd && !dn_wr && dn_addr == a;
                3: hit = execute_enable;
                default: hit = done || error;
            endcase
        end
        if (!hit) fail_now(name, "got no event, required one within 20000 cycles");
    endtask

    task automatic setup_run(input int k, input int caddr);
        for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
        corrupt_base   = pass_idx;
        corrupt_passes = k;
        corrupt_addr   = caddr;
        expect_run(k);
    endtask

    task automatic pulse_start();
        @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_ctrl"}, {dn_go, dn_wr, dn_rd, execute_enable, done, error}, 0);
        check({name, "_addr"}, {rom_addr, dn_addr}, 0);
        check({name, "_data"}, dn_data, 0);
        check({name, "_retry"}, retry_count, 0);
        check({name, "_exec_addr"}, execute_addr, ExecAddr);
    endtask

    task automatic run_and_check(input string name, input int k, input int caddr);
        int retry_e;
        bit fail_e;
        fail_e  = (k > MaxRetry);
        retry_e = fail_e ? MaxRetry : k;
        setup_run(k, caddr);
        pulse_start();
        wait_for(4, 16'd0, {name, "_timeout"});
        repeat (40) @(negedge clk_sys);
        check({name, "_done"}, done, !fail_e);
        check({name, "_error"}, error, fail_e);
        check({name, "_dn_go"}, dn_go, fail_e);
        check({name, "_retry"}, retry_count, retry_e);
        check({name, "_passes"}, pass_idx - corrupt_base, retry_e + 1);
        check({name, "_queues"}, exp_wr.size() + exp_rd.size() + exp_out.size(), 0);
    endtask

    initial begin
        bit stable;
        reset_n     = 1'b0;
        start       = 1'b0;
        sdram_ready = 1'b1;
        for (int i = 0; i < N; i++) rom[i] = 8'h00;
        repeat (4) @(negedge clk_sys);
        check_idle("reset_low");
        reset_n = 1'b1;
        repeat (60) @(negedge clk_sys);
        check_idle("idle_no_start");

        run_and_check("clean", 0, -1);
        run_and_check("single_mismatch", 1, 2);
        run_and_check("persistent", 99, int'($urandom_range(0, N - 1)));

        // Stall while the write strobe for address 1 is asserted.
        setup_run(0, -1);
        pulse_start();
        wait_for(0, 16'd1, "stall_wait");
        sdram_ready = 1'b0;
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk_sys);
            if (!(dn_wr && !dn_rd && dn_addr == 16'd1 && dn_data == rom[1])) stable = 1'b0;
        end
        check("stall_hold", stable, 1);
        sdram_ready = 1'b1;
        wait_for(4, 16'd0, "stall_timeout");
        repeat (40) @(negedge clk_sys);
        check("stall_done", {done, error, dn_go, retry_count}, 5'b10000);
        check("stall_queues", exp_wr.size() + exp_rd.size() + exp_out.size(), 0);

        // Restart while in V_SETUP at address 2.
        setup_run(0, -1);
        pulse_start();
        wait_for(1, 16'd1, "restart_wait_rd");
        wait_for(2, 16'd2, "restart_wait_vsetup");
        exp_wr.delete();
        exp_rd.delete();
        exp_out.delete();
        expect_run(0);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        check("restart_strobes", {dn_rd, dn_wr}, 0);
        check("restart_addr", dn_addr, 0);
        check("restart_go", dn_go, 1);
        check("restart_retry", retry_count, 0);
        wait_for(4, 16'd0, "restart_timeout");
        repeat (40) @(negedge clk_sys);
        check("restart_done", {done, error, dn_go, retry_count}, 5'b10000);
        check("restart_queues", exp_wr.size() + exp_rd.size() + exp_out.size(), 0);

        // Reset pulse during EXEC.
        setup_run(0, -1);
        pulse_start();
        wait_for(3, 16'd0, "reset_wait_exec");
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        check_idle("reset_exec");
        exp_out.delete();
        repeat (200) @(negedge clk_sys);
        check_idle("reset_hold");
        check("reset_queues", exp_wr.size() + exp_rd.size(), 0);

        for (int r = 0; r < 6; r++) begin
            run_and_check("random", int'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
